cplx_frame_acc: RTL

//   Complex frame accumulator placed directly after complex_mult.

---
 rtl/cplx_frame_acc.sv | 106 ++++++++++
 1 files changed

// File: rtl/cplx_frame_acc.sv
// Sums LEN complex Q5.11 samples losslessly and emits one saturated result per frame.
// Result valid the cycle after the LEN-th accept; input stalls (in_ready=0) while a result waits.
module cplx_frame_acc #(
  parameter int WIDTH = 16,
  parameter int LEN   = 8,
  parameter int CNT_W = $clog2(LEN),
  parameter int ACC_W = WIDTH + $clog2(LEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_re,
  input  logic signed [WIDTH-1:0] in_im,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_re,
  output logic signed [WIDTH-1:0] out_im,
  output logic                    out_sat
);

  typedef enum logic {S_ACC, S_OUT} state_t;

  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  state_t                   state, state_nxt;
  logic signed [ACC_W-1:0]  acc_re, acc_im;
  logic signed [ACC_W-1:0]  sum_re, sum_im;
  logic [CNT_W-1:0]         cnt;
  logic                     accept, last, take;
  logic signed [WIDTH-1:0]  sat_re, sat_im;
  logic                     clip_re, clip_im;

  // Returns {clipped, value} with the value clamped to the signed WIDTH range.
  function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v > MAXV)
      return {1'b1, MAXV[WIDTH-1:0]};
    else if (v < MINV)
      return {1'b1, MINV[WIDTH-1:0]};
    else
      return {1'b0, v[WIDTH-1:0]};
  endfunction

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;
  assign last   = (cnt == CNT_W'(LEN-1));
  assign sum_re = acc_re + {{(ACC_W-WIDTH){in_re[WIDTH-1]}}, in_re};
  assign sum_im = acc_im + {{(ACC_W-WIDTH){in_im[WIDTH-1]}}, in_im};
  assign {clip_re, sat_re} = saturate(sum_re);
  assign {clip_im, sat_im} = saturate(sum_im);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_ACC;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_ACC:   if (accept && last) state_nxt = S_OUT;
      S_OUT:   if (take)           state_nxt = S_ACC;
      default:                     state_nxt = S_ACC;
    endcase
    if (clr)
      state_nxt = S_ACC;
  end

  always_comb begin
    in_ready  = (state == S_ACC);
    out_valid = (state == S_OUT);
  end

  // clr wins over a same-cycle accept so the sample is dropped with the partial sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_re  <= '0;
      acc_im  <= '0;
      cnt     <= '0;
      out_re  <= '0;
      out_im  <= '0;
      out_sat <= 1'b0;
    end else if (clr) begin
      acc_re <= '0;
      acc_im <= '0;
      cnt    <= '0;
    end else if (accept) begin
      if (last) begin
        out_re  <= sat_re;
        out_im  <= sat_im;
        out_sat <= clip_re | clip_im;
        acc_re  <= '0;
        acc_im  <= '0;
        cnt     <= '0;
      end else begin
        acc_re <= sum_re;
        acc_im <= sum_im;
        cnt    <= cnt + CNT_W'(1);
      end
    end
  end

endmodule
